// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : piso_serializer
// Purpose  : Parallel-in/serial-out serializer with valid/ready load,
//            selectable bit order, shift-enable pacing, abort and done flag.
// Revision : 1.0 - initial release
// ============================================================================
module piso_serializer #(
   parameter int unsigned WIDTH      = 8,
   parameter bit          MSB_FIRST  = 1'b1,
   parameter bit          IDLE_LEVEL = 1'b0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic             i_en,
   input  logic             i_abort,
   output logic             o_sdata,
   output logic             o_svalid,
   output logic             o_last,
   output logic             o_done
);

   localparam int unsigned        c_CNT_W    = $clog2(WIDTH);
   localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(WIDTH - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   sh_q, sh_d;
   logic [c_CNT_W-1:0] cnt_q, cnt_d;
   logic               done_q, done_d;

   logic               w_out_bit;
   logic [WIDTH-1:0]   w_sh_shifted;
   logic               w_final_bit;

   // The output end of the shift register depends on bit order.
   generate
      if (MSB_FIRST) begin : g_msb_first
         assign w_out_bit    = sh_q[WIDTH-1];
         assign w_sh_shifted = {sh_q[WIDTH-2:0], 1'b0};
      end else begin : g_lsb_first
         assign w_out_bit    = sh_q[0];
         assign w_sh_shifted = {1'b0, sh_q[WIDTH-1:1]};
      end
   endgenerate

   assign w_final_bit = (state_q == S_SHIFT) && (cnt_q == c_LAST_CNT);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         sh_q    <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      o_ready = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (!i_abort) begin
               o_ready = 1'b1;
               if (i_valid) begin
                  sh_d    = i_data;
                  cnt_d   = '0;
                  state_d = S_SHIFT;
               end
            end
         end
         S_SHIFT: begin
            if (i_abort) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (i_en) begin
               if (cnt_q != c_LAST_CNT) begin
                  sh_d  = w_sh_shifted;
                  cnt_d = cnt_q + c_CNT_ONE;
               end else begin
                  // Final bit consumed: reload back-to-back or fall idle.
                  o_ready = 1'b1;
                  done_d  = 1'b1;
                  cnt_d   = '0;
                  if (i_valid) begin
                     sh_d = i_data;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign o_sdata  = (state_q == S_SHIFT) ? w_out_bit : IDLE_LEVEL;
   assign o_svalid = (state_q == S_SHIFT);
   assign o_last   = w_final_bit;
   assign o_done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_serializer
// Purpose  : Self-checking bench: MSB-first/idle-low and LSB-first/idle-high
//            instances driven in parallel against a word/bit-index model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         valid, en, abort;
   logic [W-1:0] data;

   logic ready_a, sdata_a, svalid_a, last_a, done_a;
   logic ready_b, sdata_b, svalid_b, last_b, done_b;

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_dut_msb (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid),
      .o_ready(ready_a), .i_en(en), .i_abort(abort), .o_sdata(sdata_a),
      .o_svalid(svalid_a), .o_last(last_a), .o_done(done_a)
   );

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_dut_lsb (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid),
      .o_ready(ready_b), .i_en(en), .i_abort(abort), .o_sdata(sdata_b),
      .o_svalid(svalid_b), .o_last(last_b), .o_done(done_b)
   );

   int n_checks = 0;
   int n_fails  = 0;

   // Reference model: the word in flight and the index of the bit on the wire.
   bit         m_active;
   bit [W-1:0] m_word;
   int         m_idx;
   bit         m_done;

   task automatic check(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s @%0t: observed %b expected %b", tag, $time, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_active = 1'b0;
      m_idx    = 0;
      m_done   = 1'b0;
   endtask

   task automatic model_edge();
      bit nd;
      nd = 1'b0;
      if (!m_active) begin
         if (!abort && valid) begin
            m_active = 1'b1;
            m_word   = data;
            m_idx    = 0;
         end
      end else if (abort) begin
         m_active = 1'b0;
         m_idx    = 0;
      end else if (en) begin
         if (m_idx < W - 1) begin
            m_idx++;
         end else begin
            nd = 1'b1;
            if (valid) begin
               m_word = data;
               m_idx  = 0;
            end else begin
               m_active = 1'b0;
            end
         end
      end
      m_done = nd;
   endtask

   task automatic check_outputs(input string tag);
      logic exp_last, exp_ready;
      exp_last  = m_active && (m_idx == W - 1);
      exp_ready = !abort && (!m_active || (exp_last && en));
      check({tag, " ready_msb"},  ready_a,  exp_ready);
      check({tag, " ready_lsb"},  ready_b,  exp_ready);
      check({tag, " sdata_msb"},  sdata_a,  m_active ? m_word[W-1-m_idx] : 1'b0);
      check({tag, " sdata_lsb"},  sdata_b,  m_active ? m_word[m_idx]     : 1'b1);
      check({tag, " svalid_msb"}, svalid_a, m_active);
      check({tag, " svalid_lsb"}, svalid_b, m_active);
      check({tag, " last_msb"},   last_a,   exp_last);
      check({tag, " last_lsb"},   last_b,   exp_last);
      check({tag, " done_msb"},   done_a,   m_done);
      check({tag, " done_lsb"},   done_b,   m_done);
   endtask

   // Called at a negative edge: drive, check, advance one clock.
   task automatic step(input string tag, input logic v, input logic [W-1:0] d,
                       input logic e, input logic a);
      valid = v;
      data  = d;
      en    = e;
      abort = a;
      #1;
      check_outputs(tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   initial begin
      bit [W-1:0] stream;
      rst_n = 1'b0;
      valid = 1'b0;
      en    = 1'b0;
      abort = 1'b0;
      data  = '0;
      m_word = '0;
      model_reset();
      #1;
      check_outputs("reset_async");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 3; i++) step("idle", 1'b0, W'($urandom), 1'b1, 1'b0);

      // Single word 8'hA5, full-rate enable; also capture the MSB-first stream.
      step("a5_load", 1'b1, 8'hA5, 1'b1, 1'b0);
      stream = '0;
      for (int i = 0; i < W; i++) begin
         stream = {stream[W-2:0], sdata_a};
         step("a5_bits", 1'b0, W'($urandom), 1'b1, 1'b0);
      end
      check("a5_stream_b7", stream[7], 1'b1);
      check("a5_stream_b0", stream[0], 1'b1);
      check("a5_stream_b3", stream[3], 1'b0);
      step("a5_done", 1'b0, '0, 1'b1, 1'b0);
      step("a5_after", 1'b0, '0, 1'b1, 1'b0);

      // Back-to-back F0 then 0F with i_valid held high.
      step("b2b_load", 1'b1, 8'hF0, 1'b1, 1'b0);
      for (int i = 0; i < W; i++) step("b2b_w0", 1'b1, 8'h0F, 1'b1, 1'b0);
      for (int i = 0; i < W + 2; i++) step("b2b_w1", 1'b0, 8'h0F, 1'b1, 1'b0);

      // Enable every third cycle: each bit held for three cycles.
      step("slow_load", 1'b1, 8'h5A, 1'b0, 1'b0);
      for (int i = 0; i < 3 * W + 3; i++)
         step("slow", 1'b0, W'($urandom), (i % 3) == 2, 1'b0);

      // Abort at bit 3 with a simultaneous valid, then a clean reload.
      step("abt_load", 1'b1, 8'hFF, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step("abt_pre", 1'b0, '0, 1'b1, 1'b0);
      step("abt_hit", 1'b1, 8'h12, 1'b1, 1'b1);
      step("abt_idle", 1'b0, '0, 1'b1, 1'b0);
      step("abt_reload", 1'b1, 8'h3C, 1'b1, 1'b0);
      for (int i = 0; i < W + 1; i++) step("abt_word", 1'b0, '0, 1'b1, 1'b0);

      // Abort in idle blocks a load; abort on the final bit blocks reload and done.
      step("abt_in_idle", 1'b1, 8'h99, 1'b1, 1'b1);
      step("fin_load", 1'b1, 8'hC3, 1'b1, 1'b0);
      for (int i = 0; i < W - 1; i++) step("fin_bits", 1'b0, '0, 1'b1, 1'b0);
      step("fin_abort", 1'b1, 8'h81, 1'b1, 1'b1);
      step("fin_after", 1'b0, '0, 1'b1, 1'b0);

      // Asynchronous reset mid-word.
      step("rst_load", 1'b1, 8'hE7, 1'b1, 1'b0);
      step("rst_bit", 1'b0, '0, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("reset_mid");
      @(negedge clk);
      rst_n = 1'b1;
      step("rst_after", 1'b0, '0, 1'b1, 1'b0);

      // Randomised traffic.
      for (int i = 0; i < 400; i++)
         step("rand", ($urandom_range(0, 1) == 1), W'($urandom),
              ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/piso_serializer.md
# piso_serializer

Parametrised parallel-in/serial-out serializer with a valid/ready load handshake, selectable bit order, shift-enable pacing, abort and end-of-word flags. It sits between a word-oriented producer and a bit-serial link (UART/SPI-style TX paths). It also replaces the fixed 4-bit shift/load register in new designs. Back-to-back words stream with no idle bit between them.

## Interface
- WIDTH, 8, word width in bits; must be >= 2.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is transmitted first; 0 = bit 0 is transmitted first.
- IDLE_LEVEL, 0, value driven on o_sdata while no word is being shifted.

- i_clk  input  1  single clock; all state changes on rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_data  input  WIDTH  parallel word to serialize.
- i_valid  input  1  i_data is valid.
- o_ready  output  1  block accepts i_data this cycle; a load occurs when i_valid && o_ready at the rising edge.
- i_en  input  1  shift enable / bit tick; the current bit is consumed on an edge with i_en=1.
- i_abort  input  1  synchronous abort of the word in flight.
- o_sdata  output  1  serial data.
- o_svalid  output  1  o_sdata carries a word bit.
- o_last  output  1  current bit is the final bit of the word.
- o_done  output  1  one-cycle pulse: the final bit was consumed.

## Operation
- States: IDLE, SHIFT. Internal registers: shift register sh[WIDTH-1:0] and bit counter cnt of width $clog2(WIDTH).
- Reset (asynchronous, i_rst_n=0) sets state=IDLE, sh=0, cnt=0, o_done=0.
- Output reset values: o_ready=1, o_sdata=IDLE_LEVEL, o_svalid=0, o_last=0, o_done=0.
- IDLE:
  - o_ready=1, o_sdata=IDLE_LEVEL, o_svalid=0.
  - On i_valid=1: sh<=i_data, cnt<=0, state<=SHIFT. i_en is ignored in IDLE.
- SHIFT outputs:
  - o_sdata = sh[WIDTH-1] when MSB_FIRST=1, else sh[0].
  - o_svalid=1.
  - o_last = (cnt==WIDTH-1).
- SHIFT, i_en=0: all state holds and o_sdata is stable.
- SHIFT, i_en=1 and cnt<WIDTH-1: sh shifts toward the output end (left when MSB_FIRST=1, right otherwise), zero-filled. cnt increments.
- SHIFT, i_en=1 and cnt==WIDTH-1 (final bit consumed): o_done pulses on the next cycle.
  - If i_valid=1: reload sh<=i_data, cnt<=0, remain in SHIFT (back-to-back).
  - Otherwise: state<=IDLE.
- o_ready is combinational: IDLE, or (SHIFT && cnt==WIDTH-1 && i_en && !i_abort). It is never asserted mid-word.
- i_abort=1 in SHIFT: state<=IDLE, cnt<=0 on the next edge. No o_done pulse; the word is discarded. Abort overrides any simultaneous reload.
- i_abort=1 in IDLE: the abort takes priority; no load occurs and o_ready=0 for that cycle.
- i_data changes while in SHIFT have no effect; the word is captured only at the handshake.
- Reset asserted mid-word returns to IDLE immediately (asynchronously). The partial word is lost and o_done is not pulsed.

## Timing
- Load latency: handshake at edge k; the first bit appears on o_sdata after edge k (cycle k+1).
- With i_en held at 1, each word occupies exactly WIDTH cycles of o_svalid=1. Bit n is presented in cycle k+1+n.
- With continuous i_valid and i_en=1, o_svalid stays 1 with no gap between words. Throughput is 1 bit/cycle.
- With i_en pulsed every N cycles, each bit is held for N cycles. o_last is asserted for the whole final-bit hold.
- o_done is registered and asserted in the cycle after the final bit's consuming edge. It coincides with the first bit of the next word when words run back-to-back.
- o_sdata, o_svalid and o_last are decoded from registered state only; they are not combinational from inputs.

## Test plan
- Reset with i_rst_n=0 mid-stream: outputs go to o_ready=1, o_sdata=IDLE_LEVEL, o_svalid=0, o_done=0 without waiting for a clock edge. Repeat with IDLE_LEVEL=1.
- WIDTH=8, MSB_FIRST=1, i_en=1, load 8'hA5: o_sdata = 1,0,1,0,0,1,0,1 in cycles k+1..k+8. o_last only in cycle k+8, o_done in cycle k+9, then IDLE.
- MSB_FIRST=0, load 8'hA5: o_sdata = 1,0,1,0,0,1,0,1 (LSB first), 8 cycles.
- Back-to-back with i_valid held high: 8'hF0 followed by 8'h0F gives 16 consecutive o_svalid cycles carrying 1111_0000_0000_1111. o_ready pulses only on the final-bit cycle.
- i_en asserted every 3rd cycle, WIDTH=4, load 4'b1010: each bit is held for 3 cycles. The word spans 12 cycles and o_done pulses once.
- i_abort asserted at bit 3 of 8'hFF: IDLE on the next edge, o_sdata=IDLE_LEVEL, no o_done. A new load on the following cycle transmits correctly from bit 0.
